// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: read-owner encoding,
// memory map constants and peripheral word indices.
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] PERI_NIBBLE  = 4'h4;
    localparam int         RAM_SIZE_BIT = 9;

    typedef enum logic [3:0] {
        TIMER_TH      = 4'd0,
        TIMER_CNT     = 4'd1,
        TIMER_CTRL    = 4'd2,
        GPIO_OUT      = 4'd3,
        GPIO_IN       = 4'd4,
        GPIO_DIR      = 4'd5,
        SEG_DATA      = 4'd6,
        SEG_CTRL      = 4'd7,
        UART_RX_DATA  = 4'd8,
        UART_RX_VALID = 4'd9,
        UART_TX_DATA  = 4'd10,
        UART_TX_DONE  = 4'd11
    } peri_word_t;

    function automatic logic is_peri(input logic [31:0] addr);
        return addr[31:28] == PERI_NIBBLE;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU port, loader port and memory-side signals around the arbiter.
interface dmem_port_arbiter_if;

    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_read;
    logic        m_write;
    logic        m_peri;
    logic [31:0] m_rdata;

    // The arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_addr, m_wdata, m_read, m_write, m_peri,
        input  m_rdata
    );

    // Requesters plus memory, seen from outside the arbiter
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_addr, m_wdata, m_read, m_write, m_peri,
        output m_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Counts consecutive cycles the loader is refused; force_d lets it win the
// next conflict once the count reaches MAX_WAIT.
module dmem_starve_ctr #(
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_req,
    input  logic d_gnt,
    output logic force_d
);

    logic [WAIT_BITS-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (d_req && !d_gnt) begin
            if (wait_cnt != WAIT_BITS'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign force_d = (wait_cnt == WAIT_BITS'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (C, priority)
// and the UART loader (D), routing registered read data back to the issuer.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_port_arbiter_if.slave    bus
);

    logic   force_d;
    logic   win_c;
    logic   win_d;
    logic   d_reject;
    logic   issue_d;
    logic   [31:0] mux_addr;
    owner_t rd_owner;
    owner_t rd_owner_next;

    dmem_starve_ctr #(
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_BITS (WAIT_BITS)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .d_req   (bus.d_req),
        .d_gnt   (win_d),
        .force_d (force_d)
    );

    // A rejected D access still wins the cycle; it just never reaches memory.
    always_comb begin
        d_reject = (bus.d_addr[1:0] != 2'b00)
                || is_peri(bus.d_addr)
                || (bus.d_addr[31:RAM_SIZE_BIT+2] != '0);
        win_c    = bus.c_req && !(bus.d_req && force_d);
        win_d    = bus.d_req && !win_c;
        issue_d  = win_d && !d_reject;

        if (win_c) begin
            mux_addr    = bus.c_addr;
            bus.m_wdata = bus.c_wdata;
        end else if (win_d) begin
            mux_addr    = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
        end else begin
            mux_addr    = '0;
            bus.m_wdata = '0;
        end

        bus.m_addr  = mux_addr;
        bus.m_peri  = is_peri(mux_addr);
        bus.m_read  = (win_c && !bus.c_we) || (issue_d && !bus.d_we);
        bus.m_write = (win_c && bus.c_we) || (issue_d && bus.d_we);
        bus.c_gnt   = win_c;
        bus.d_gnt   = win_d;
        bus.d_err   = win_d && d_reject;

        if (win_c && !bus.c_we)
            rd_owner_next = OWN_C;
        else if (issue_d && !bus.d_we)
            rd_owner_next = OWN_D;
        else
            rd_owner_next = OWN_NONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_owner <= OWN_NONE;
        else
            rd_owner <= rd_owner_next;
    end

    always_comb begin
        bus.c_rvalid = (rd_owner == OWN_C);
        bus.d_rvalid = (rd_owner == OWN_D);
        bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : 32'd0;
        bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Random and directed traffic on both ports against a reference of the arbitration
// rules and a shadow memory; read responses are checked by a separate monitor.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 8;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] seed_ram(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    function automatic logic [31:0] seed_peri(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101;
    endfunction

    // Memory behind the arbiter: registered read, write on the edge.
    logic [31:0] ram_env  [0:511];
    logic [31:0] peri_env [0:15];
    initial begin
        for (int i = 0; i < 512; i++) ram_env[i] = seed_ram(i);
        for (int i = 0; i < 16; i++) peri_env[i] = seed_peri(i);
        forever begin
            @(posedge clk);
            if (bus.m_write) begin
                if (bus.m_peri) peri_env[bus.m_addr[5:2]] = bus.m_wdata;
                else            ram_env[bus.m_addr[10:2]] = bus.m_wdata;
            end
            if (bus.m_read)
                bus.m_rdata <= bus.m_peri ? peri_env[bus.m_addr[5:2]] : ram_env[bus.m_addr[10:2]];
        end
    end

    // Requesters must hold their fields while waiting for a grant.
    logic        c_hold = 1'b0, d_hold = 1'b0;
    logic [64:0] c_snap, d_snap;
    always @(posedge clk) begin
        if (c_hold) assert ({bus.c_we, bus.c_addr, bus.c_wdata} == c_snap)
            else $error("[TB] c request fields changed while waiting");
        if (d_hold) assert ({bus.d_we, bus.d_addr, bus.d_wdata} == d_snap)
            else $error("[TB] d request fields changed while waiting");
        c_hold <= reset && bus.c_req && !bus.c_gnt;
        d_hold <= reset && bus.d_req && !bus.d_gnt;
        c_snap <= {bus.c_we, bus.c_addr, bus.c_wdata};
        d_snap <= {bus.d_we, bus.d_addr, bus.d_wdata};
    end

    // Reference state
    logic [31:0] ram_ref  [0:511];
    logic [31:0] peri_ref [0:15];
    txn_t        c_q[$], d_q[$];
    logic [31:0] c_exp[$], d_exp[$];
    txn_t        c_cur, d_cur;
    bit          c_act = 0, d_act = 0;
    int          refusals = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit d_illegal(input bit [31:0] a);
        return (a % 4 != 0) || ((a >> 28) == 4) || (a >= 32'd2048);
    endfunction

    function automatic logic [31:0] read_ref(input bit [31:0] a);
        return ((a >> 28) == 4) ? peri_ref[(a >> 2) % 16] : ram_ref[(a >> 2) % 512];
    endfunction

    task automatic write_ref(input bit [31:0] a, input bit [31:0] d);
        if ((a >> 28) == 4) peri_ref[(a >> 2) % 16] = d;
        else                ram_ref[(a >> 2) % 512] = d;
    endtask

    task automatic checkOutput(input bit exp_c, input bit exp_d, input bit exp_err);
        logic [31:0] ea, ew;
        ea = exp_c ? c_cur.addr  : exp_d ? d_cur.addr  : 32'd0;
        ew = exp_c ? c_cur.wdata : exp_d ? d_cur.wdata : 32'd0;
        checkVal("c_gnt", 32'(bus.c_gnt), 32'(exp_c));
        checkVal("d_gnt", 32'(bus.d_gnt), 32'(exp_d));
        checkVal("d_err", 32'(bus.d_err), 32'(exp_err));
        checkVal("m_read", 32'(bus.m_read),
                 32'((exp_c && !c_cur.we) || (exp_d && !exp_err && !d_cur.we)));
        checkVal("m_write", 32'(bus.m_write),
                 32'((exp_c && c_cur.we) || (exp_d && !exp_err && d_cur.we)));
        checkVal("m_addr", bus.m_addr, ea);
        checkVal("m_wdata", bus.m_wdata, ew);
        checkVal("m_peri", 32'(bus.m_peri), 32'(ea[31:28] == 4'h4));
    endtask

    // One clock of traffic: drive at negedge, predict and compare just after.
    task automatic applyStimulus();
        bit exp_c, exp_d, exp_err, d_was;
        @(negedge clk);
        if (!c_act && c_q.size() > 0) begin c_cur = c_q.pop_front(); c_act = 1; end
        if (!d_act && d_q.size() > 0) begin d_cur = d_q.pop_front(); d_act = 1; end
        bus.c_req = c_act; bus.c_we = c_cur.we; bus.c_addr = c_cur.addr; bus.c_wdata = c_cur.wdata;
        bus.d_req = d_act; bus.d_we = d_cur.we; bus.d_addr = d_cur.addr; bus.d_wdata = d_cur.wdata;
        #1;
        exp_c   = c_act && !(d_act && refusals >= MAX_WAIT);
        exp_d   = d_act && !exp_c;
        exp_err = exp_d && d_illegal(d_cur.addr);
        checkOutput(exp_c, exp_d, exp_err);
        d_was = d_act;
        if (exp_c) begin
            if (c_cur.we) write_ref(c_cur.addr, c_cur.wdata);
            else          c_exp.push_back(read_ref(c_cur.addr));
            c_act = 0;
        end
        if (exp_d) begin
            if (!exp_err) begin
                if (d_cur.we) write_ref(d_cur.addr, d_cur.wdata);
                else          d_exp.push_back(read_ref(d_cur.addr));
            end
            d_act = 0;
        end
        refusals = (d_was && !exp_d) ? ((refusals < MAX_WAIT) ? refusals + 1 : MAX_WAIT) : 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((c_act || d_act || c_q.size() > 0 || d_q.size() > 0) && n < 300) begin
            applyStimulus();
            n++;
        end
        if (n >= 300) checkVal("drain_timeout", 32'd1, 32'd0);
        applyStimulus();
    endtask

    function automatic txn_t mk(input bit we, input bit [31:0] a, input bit [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_c();
        bit [31:0] a;
        if ($urandom % 8 == 0) a = 32'h4000_0000 | ($urandom_range(0, 11) << 2);
        else if ($urandom % 2 == 0) a = ($urandom % 16) << 2;
        else a = ($urandom % 512) << 2;
        return mk(1'($urandom % 2), a, $urandom);
    endfunction

    function automatic txn_t rand_d();
        bit [31:0] a;
        case ($urandom % 8)
            0: a = (($urandom % 512) << 2) | $urandom_range(1, 3);
            1: a = 32'h800 + (($urandom % 64) << 2);
            2: a = 32'h4000_0000 | ($urandom_range(0, 11) << 2);
            default: a = ($urandom % 16) << 2;
        endcase
        return mk(1'($urandom % 2), a, $urandom);
    endfunction

    // Response monitor: a read issued last cycle must come back on its own port only.
    initial begin
        logic [31:0] ed;
        bit ev;
        forever begin
            @(posedge clk);
            #2;
            ev = c_exp.size() > 0;
            ed = ev ? c_exp.pop_front() : 32'd0;
            checkVal("c_rvalid", 32'(bus.c_rvalid), 32'(ev));
            checkVal("c_rdata", bus.c_rdata, ed);
            ev = d_exp.size() > 0;
            ed = ev ? d_exp.pop_front() : 32'd0;
            checkVal("d_rvalid", 32'(bus.d_rvalid), 32'(ev));
            checkVal("d_rdata", bus.d_rdata, ed);
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) ram_ref[i] = seed_ram(i);
        for (int i = 0; i < 16; i++) peri_ref[i] = seed_peri(i);
        c_cur = mk(0, 0, 0);
        d_cur = mk(0, 0, 0);
        reset = 1'b0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset
        repeat (5) applyStimulus();

        // Single CPU read of the preloaded word
        c_q.push_back(mk(0, 32'h10, 0));
        drain();

        // Both ports saturated: D must break through every MAX_WAIT+1 cycles
        for (int i = 0; i < 24; i++) c_q.push_back(mk(0, 32'((i % 16) << 2), 0));
        for (int i = 0; i < 3; i++) d_q.push_back(mk(0, 32'((i + 8) << 2), 0));
        drain();

        // Loader write into the peripheral region is refused
        d_q.push_back(mk(1, 32'h4000_0004, 32'hCAFE_F00D));
        drain();
        checkVal("timer_kept", peri_env[1], seed_peri(1));

        // Same-cycle C write and D read of one word: D sees the new value
        c_q.push_back(mk(1, 32'h20, 32'h55));
        d_q.push_back(mk(0, 32'h20, 0));
        drain();

        // Reset during the response cycle drops the pending read
        @(negedge clk);
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.d_req = 0;
        #1;
        checkVal("rst_c_gnt", 32'(bus.c_gnt), 32'd1);
        @(posedge clk);
        #0.5;
        checkVal("rst_pre_rvalid", 32'(bus.c_rvalid), 32'd1);
        #0.5;
        reset = 1'b0;
        bus.c_req = 0;
        #1;
        checkVal("rst_rvalid", 32'(bus.c_rvalid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c_act = 0; d_act = 0; refusals = 0;
        repeat (3) applyStimulus();

        // Randomized mixed traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_act && c_q.size() == 0 && $urandom % 3 != 0) c_q.push_back(rand_c());
            if (!d_act && d_q.size() == 0 && $urandom % 2 != 0) d_q.push_back(rand_d());
            applyStimulus();
        end
        drain();
        repeat (2) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
